// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding, defaults and frame layout for the instruction loader
package loader_pkg;

  localparam int IMEM_DEPTH_DEF = 64;
  localparam int LEN_W          = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  // Order of fields in a load frame as they arrive on the byte stream
  typedef enum logic [2:0] {
    F_LEN_HI,
    F_LEN_LO,
    F_DATA_HI,
    F_DATA_LO,
    F_CHK
  } field_t;

endpackage

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - byte stream in and instruction memory write port out
interface instr_mem_loader_if #(
  parameter int ADDR_W = 16
);

  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              rx_ready;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;

  modport slave (
    input  rx_valid, rx_byte,
    output rx_ready, imem_wr_en, imem_addr, imem_wdata
  );

  modport master (
    output rx_valid, rx_byte,
    input  rx_ready, imem_wr_en, imem_addr, imem_wdata
  );

endinterface

// File: rtl/xor_csum8.sv
// rtl/xor_csum8.sv - 8-bit running XOR checksum accumulator
module xor_csum8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      sum <= 8'd0;
    end else if (en) begin
      sum <= sum ^ din;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - loads a length-prefixed, checksummed word stream into instruction memory
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int ADDR_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  instr_mem_loader_if.slave   bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                error
);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             restart;
  logic             csum_en;
  logic [7:0]       csum;
  logic [7:0]       len_hi;
  logic [7:0]       data_hi;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] n_rx;
  logic             last_word;

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign restart   = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign n_rx      = {len_hi, bus.rx_byte};
  assign last_word = (idx + 16'd1) == len;
  assign csum_en   = accept && (state == S_LEN_HI || state == S_LEN_LO ||
                                state == S_DATA_HI || state == S_DATA_LO);

  xor_csum8 u_csum (
    .clk   (clk),
    .rst   (rst),
    .clear (restart),
    .en    (csum_en),
    .din   (bus.rx_byte),
    .sum   (csum)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start)  state_nxt = S_LEN_HI;
      S_LEN_HI:  if (accept) state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if ({16'd0, n_rx} > 32'(IMEM_DEPTH)) state_nxt = S_ERR;
          else if (n_rx == 16'd0)              state_nxt = S_CHECK;
          else                                 state_nxt = S_DATA_HI;
        end
      end
      S_DATA_HI: if (accept) state_nxt = S_DATA_LO;
      S_DATA_LO: if (accept) state_nxt = last_word ? S_CHECK : S_DATA_HI;
      S_CHECK:   if (accept) state_nxt = (bus.rx_byte == csum) ? S_DONE : S_ERR;
      S_DONE,
      S_ERR:     if (start)  state_nxt = S_LEN_HI;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.rx_ready = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA_HI) ||
                   (state == S_DATA_LO) || (state == S_CHECK);
    cpu_hold     = (state != S_DONE);
    done         = (state == S_DONE);
    error        = (state == S_ERR);
  end

  // Write port registers hold their last values between strobes
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.imem_wr_en <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= 16'd0;
      len_hi         <= 8'd0;
      data_hi        <= 8'd0;
      len            <= '0;
      idx            <= '0;
    end else begin
      bus.imem_wr_en <= 1'b0;
      if (restart) idx <= '0;
      if (accept) begin
        case (state)
          S_LEN_HI:  len_hi  <= bus.rx_byte;
          S_LEN_LO:  len     <= n_rx;
          S_DATA_HI: data_hi <= bus.rx_byte;
          S_DATA_LO: begin
            bus.imem_wr_en <= 1'b1;
            bus.imem_addr  <= ADDR_W'(idx);
            bus.imem_wdata <= {data_hi, bus.rx_byte};
            idx            <= idx + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - scoreboard bench for instr_mem_loader with directed frames
module tb_instr_mem_loader;
  import loader_pkg::*;

  localparam int ADDR_W = 16;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  logic cpu_hold;
  logic done;
  logic error;

  instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_mem_loader #(.IMEM_DEPTH(IMEM_DEPTH_DEF), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    string       name;
    logic        d;
    logic        e;
    logic        h;
    logic        r;
    logic        chk_bus;
    logic [15:0] addr;
    logic [15:0] data;
    logic        timeout;
  } st_t;

  wr_t wr_q[$];
  st_t st_q[$];
  wr_t we;
  st_t se;
  int  checks = 0;
  int  errors = 0;

  // Monitor: every write strobe is matched against the scoreboard, status requests are drained
  always @(negedge clk) begin
    if (bus.imem_wr_en) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", bus.imem_addr, bus.imem_wdata);
      end else begin
        we = wr_q.pop_front();
        if (bus.imem_addr != we.addr || bus.imem_wdata != we.data) begin
          errors++;
          $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                   bus.imem_addr, bus.imem_wdata, we.addr, we.data);
        end
      end
    end
    while (st_q.size() > 0) begin
      se = st_q.pop_front();
      checks++;
      if (se.timeout) begin
        errors++;
        $display("FAIL %s: rx_ready never rose, expected byte accepted", se.name);
      end else begin
        if ({done, error, cpu_hold, bus.rx_ready} != {se.d, se.e, se.h, se.r}) begin
          errors++;
          $display("FAIL %s: got done/error/hold/ready=%b%b%b%b, expected %b%b%b%b", se.name,
                   done, error, cpu_hold, bus.rx_ready, se.d, se.e, se.h, se.r);
        end
        if (se.chk_bus) begin
          checks++;
          if ({bus.imem_wr_en, bus.imem_addr, bus.imem_wdata} != {1'b0, se.addr, se.data}) begin
            errors++;
            $display("FAIL %s_bus: got wr_en=%b addr=%h data=%h, expected wr_en=0 addr=%h data=%h",
                     se.name, bus.imem_wr_en, bus.imem_addr, bus.imem_wdata, se.addr, se.data);
          end
        end
        checks++;
        if (wr_q.size() != 0) begin
          errors++;
          $display("FAIL %s_pending: got %0d writes outstanding, expected 0", se.name, wr_q.size());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_st(input string name, input logic d, input logic e, input logic h, input logic r,
                         input logic cb, input logic [15:0] a, input logic [15:0] dt, input logic to);
    st_t s;
    s.name = name; s.d = d; s.e = e; s.h = h; s.r = r;
    s.chk_bus = cb; s.addr = a; s.data = dt; s.timeout = to;
    st_q.push_back(s);
  endtask

  task automatic expect_st(input string name, input logic d, input logic e, input logic h, input logic r);
    push_st(name, d, e, h, r, 1'b0, 16'd0, 16'd0, 1'b0);
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [15:0] dt);
    wr_t w;
    w.addr = a; w.data = dt;
    wr_q.push_back(w);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b0;
    tick(gap);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    for (int i = 0; i < 20; i++) begin
      if (bus.rx_ready) begin
        tick(1);
        bus.rx_valid = 1'b0;
        return;
      end
      tick(1);
    end
    bus.rx_valid = 1'b0;
    push_st("rx_timeout", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'd0;
    tick(2);
    push_st("reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0);
    rst = 1'b1;
    tick(1);

    // Bytes offered while idle are never taken
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'hAA;
    tick(3);
    bus.rx_valid = 1'b0;
    expect_st("idle_ignore", 1'b0, 1'b0, 1'b1, 1'b0);

    // Good two-word frame, with a stray start mid-session
    pulse_start();
    expect_st("t1_len_hi", 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h00, 0); send(8'h02, 0);
    pulse_start();
    send(8'h12, 0);
    expect_wr(16'h0000, 16'h1234);
    send(8'h34, 0);
    send(8'hAB, 1);
    expect_wr(16'h0001, 16'hABCD);
    send(8'hCD, 0);
    send(8'h42, 0);
    push_st("t1_done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 16'hABCD, 1'b0);

    // Same frame, bad checksum
    pulse_start();
    expect_st("t2_restart", 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h00, 0); send(8'h02, 0); send(8'h12, 0);
    expect_wr(16'h0000, 16'h1234);
    send(8'h34, 0); send(8'hAB, 0);
    expect_wr(16'h0001, 16'hABCD);
    send(8'hCD, 0);
    send(8'h43, 0);
    expect_st("t2_err", 1'b0, 1'b1, 1'b1, 1'b0);

    // Length one past capacity
    pulse_start();
    send(8'h00, 0); send(8'h41, 0);
    expect_st("t3_len_err", 1'b0, 1'b1, 1'b1, 1'b0);
    tick(5);
    push_st("t3_still_err", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001, 16'hABCD, 1'b0);

    // Empty frame with gaps between bytes
    pulse_start();
    send(8'h00, 2); send(8'h00, 3); send(8'h00, 1);
    expect_st("t4_zero_done", 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset after the first data word, then a clean reload from address 0
    pulse_start();
    send(8'h00, 0); send(8'h02, 0); send(8'h12, 0);
    expect_wr(16'h0000, 16'h1234);
    send(8'h34, 0);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    push_st("t5_reset_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0);
    tick(2);
    pulse_start();
    send(8'h00, 0); send(8'h01, 0); send(8'h55, 0);
    expect_wr(16'h0000, 16'h55AA);
    send(8'hAA, 0);
    send(8'hFE, 0);
    push_st("t5_reload_done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h55AA, 1'b0);

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
